steer_quad_multi: RTL and testbench
===================================

Name: steer_quad_multi

Overview:
Parametrised successor to the single-wheel steering front end in the Super Bug input path. It handles NUM_CH quadrature encoder channels. Each channel's pins are synchronised, glitch-filtered and 4x decoded into a signed position counter, with sticky steer, direction and error flags. Outputs are CPU-readable through a registered select port, and each channel has its own clear strobe, generalising SteerReset_n to per-channel clears. The block sits between the cabinet steering pins and the Input data-bus mux, in the Clk6 domain.

Parameters:
NUM_CH, 2, number of encoder channels (1..8)
CNT_W, 4, signed counter width per channel (3..8)
FILT_LEN, 3, consecutive equal synced samples required to accept a new pin level (1..8)
SATURATE, 1, 1 = counter clamps at limits; 0 = two's-complement wrap

Ports:
Clk6  in  1  system clock; all logic on its rising edge
Reset  in  1  synchronous, active-high reset
SteerA_n  in  NUM_CH  encoder phase A per channel, active low, asynchronous
SteerB_n  in  NUM_CH  encoder phase B per channel, active low, asynchronous
Clr  in  NUM_CH  per-channel clear strobe, one Clk6 wide, active high
Sel  in  3  channel index for readback
RdData  out  CNT_W+3  {Flag, Dir, Err, Count[CNT_W-1:0]} of the selected channel, registered
Flags  out  NUM_CH  live steer flag per channel

Behaviour:
- Reset (synchronous, active high) clears:
  - sync flops, filter history, filtered A/B, Count, Flag, Dir, Err, RdData, Flags, and the primed bit, all to 0.
- Input path, per channel:
  - Invert pins to active high, then pass through a 2-flop synchroniser.
  - The filtered level changes only when the last FILT_LEN synced samples all equal the new value.
- Priming: the first cycle after Reset deasserts loads prev={A,B} from the filtered level and sets primed. No count is made that cycle.
- Decode on filtered {A,B} vs prev:
  - +1 sequence: 00->01->11->10->00.
  - -1 sequence: the reverse.
  - No change: nothing happens.
  - Both bits change: illegal. No count; Err is set (sticky); prev is updated.
- Count event:
  - Count += or -= 1.
  - SATURATE=1: clamp at +(2^(CNT_W-1)-1) and -2^(CNT_W-1).
  - SATURATE=0: wrap.
  - Set Flag=1. Dir=1 for +1, Dir=0 for -1. Dir holds its value between events.
  - A saturated event still sets Flag and Dir.
- Latency: a clean pin edge held stable changes Count exactly FILT_LEN+3 Clk6 edges after the first edge that samples it.
- Clr[i]:
  - Clears Count, Flag, Dir and Err of channel i on the next edge.
  - If a count event occurs in the same cycle, the clear wins and the event is discarded.
  - prev still tracks the pins, so no spurious count follows the clear.
- Readback:
  - RdData is registered from channel Sel, so it shows state one cycle old.
  - Sel >= NUM_CH gives all zeros.
- Flags[i] equals channel i's Flag register (no extra delay).
- Reset mid-operation takes priority over everything, including Clr and count events.

Test Plan:
- Reset then idle pins (all 1): RdData=0 and Flags=0 for all channels; no count after priming.
- Ch0 four clockwise steps (A_n,B_n: 11->10->00->01->11, each held 10 cycles): Count=+4, Flag=1, Dir=1, Err=0. First change appears exactly 6 cycles after the first pin edge (FILT_LEN=3).
- Ch1 glitches (2-cycle pulses on A_n) plus one simultaneous A/B toggle: Count=0, Err=1, Flag=0; ch0 unaffected.
- Ch0 ten counter-clockwise steps, CNT_W=4, SATURATE=1: Count=-8 (4'b1000), Dir=0. Rerun with SATURATE=0: ten steps give Count=+6.
- Clr[0] asserted in the same cycle a count event lands: Count=0, Flag=0, Dir=0 afterwards. The next real step gives Count=±1.
- Sel sweep 0..7 with NUM_CH=2: RdData follows Sel with 1-cycle latency; Sel=2..7 reads 0. Reset asserted mid-sequence zeroes everything on the next edge.

Source files
------------

// File: rtl/steer_quad_multi.sv
// Multi-channel quadrature steering front end: sync, glitch filter, 4x decode, sticky flags.
// Latency: pin edge to Count is FILT_LEN+3 edges, and RdData adds one more; inputs are always accepted, with no backpressure.
module steer_quad_multi #(
    parameter int NUM_CH   = 2,
    parameter int CNT_W    = 4,
    parameter int FILT_LEN = 3,
    parameter bit SATURATE = 1'b1
) (
    input  logic              Clk6,
    input  logic              Reset,
    input  logic [NUM_CH-1:0] SteerA_n,
    input  logic [NUM_CH-1:0] SteerB_n,
    input  logic [NUM_CH-1:0] Clr,
    input  logic [2:0]        Sel,
    output logic [CNT_W+2:0]  RdData,
    output logic [NUM_CH-1:0] Flags
);
    localparam logic [CNT_W-1:0] CNT_MAX = {1'b0, {(CNT_W-1){1'b1}}};
    localparam logic [CNT_W-1:0] CNT_MIN = {1'b1, {(CNT_W-1){1'b0}}};

    logic             primed;
    logic [CNT_W+2:0] rd_vec [8];

    always_ff @(posedge Clk6) begin
        if (Reset) primed <= 1'b0;
        else       primed <= 1'b1;
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [1:0]          sync1, sync2, filt, prev;
        logic [FILT_LEN-1:0] hist_a, hist_b;
        logic [CNT_W-1:0]    count, count_nxt;
        logic                flag, dir, err;
        logic                inc, dec, illegal;

        // {prev, filt} pairs; decoding is held off until prev has been primed.
        always_comb begin
            inc     = 1'b0;
            dec     = 1'b0;
            illegal = 1'b0;
            if (primed) begin
                case ({prev, filt})
                    4'b0001, 4'b0111, 4'b1110, 4'b1000: inc     = 1'b1;
                    4'b0100, 4'b1101, 4'b1011, 4'b0010: dec     = 1'b1;
                    4'b0011, 4'b0110, 4'b1001, 4'b1100: illegal = 1'b1;
                    default: ;
                endcase
            end
        end

        always_comb begin
            count_nxt = count;
            if (inc) begin
                if (!(SATURATE && count == CNT_MAX)) count_nxt = count + CNT_W'(1);
            end else if (dec) begin
                if (!(SATURATE && count == CNT_MIN)) count_nxt = count - CNT_W'(1);
            end
        end

        always_ff @(posedge Clk6) begin
            if (Reset) begin
                sync1  <= '0;
                sync2  <= '0;
                hist_a <= '0;
                hist_b <= '0;
                filt   <= '0;
                prev   <= '0;
                count  <= '0;
                flag   <= 1'b0;
                dir    <= 1'b0;
                err    <= 1'b0;
            end else begin
                sync1  <= ~{SteerA_n[i], SteerB_n[i]};
                sync2  <= sync1;
                hist_a <= (hist_a << 1) | FILT_LEN'(sync2[1]);
                hist_b <= (hist_b << 1) | FILT_LEN'(sync2[0]);
                if (&hist_a)       filt[1] <= 1'b1;
                else if (~|hist_a) filt[1] <= 1'b0;
                if (&hist_b)       filt[0] <= 1'b1;
                else if (~|hist_b) filt[0] <= 1'b0;
                // prev always follows filt so a clear or illegal jump never leaves a stale phase behind.
                prev <= filt;
                if (Clr[i]) begin
                    count <= '0;
                    flag  <= 1'b0;
                    dir   <= 1'b0;
                    err   <= 1'b0;
                end else begin
                    if (inc || dec) begin
                        count <= count_nxt;
                        flag  <= 1'b1;
                        dir   <= inc;
                    end
                    if (illegal) err <= 1'b1;
                end
            end
        end

        assign rd_vec[i] = {flag, dir, err, count};
        assign Flags[i]  = flag;
    end

    for (genvar j = NUM_CH; j < 8; j++) begin : g_pad
        assign rd_vec[j] = '0;
    end

    always_ff @(posedge Clk6) begin
        if (Reset) RdData <= '0;
        else       RdData <= rd_vec[Sel];
    end
endmodule

// File: tb/tb_steer_quad_multi.sv
// Bench for steer_quad_multi: saturating and wrapping instances share stimulus, checked via a scoreboard queue.
module tb_steer_quad_multi;
    localparam int NUM_CH = 2;
    localparam int CNT_W  = 4;

    logic              Clk6 = 1'b0;
    logic              Reset;
    logic [NUM_CH-1:0] SteerA_n, SteerB_n, Clr;
    logic [2:0]        Sel;
    logic [CNT_W+2:0]  rd_s, rd_w;
    logic [NUM_CH-1:0] flags_s, flags_w;

    always #5 Clk6 = ~Clk6;

    steer_quad_multi #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .FILT_LEN(3), .SATURATE(1'b1)) dut_s (
        .Clk6(Clk6), .Reset(Reset), .SteerA_n(SteerA_n), .SteerB_n(SteerB_n),
        .Clr(Clr), .Sel(Sel), .RdData(rd_s), .Flags(flags_s)
    );

    steer_quad_multi #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .FILT_LEN(3), .SATURATE(1'b0)) dut_w (
        .Clk6(Clk6), .Reset(Reset), .SteerA_n(SteerA_n), .SteerB_n(SteerB_n),
        .Clr(Clr), .Sel(Sel), .RdData(rd_w), .Flags(flags_w)
    );

    // kind: 0 = RdData sat, 1 = Flags sat, 2 = RdData wrap, 3 = Flags wrap
    typedef struct {
        int         kind;
        logic [7:0] exp;
        string      name;
    } exp_t;

    exp_t       sbq[$];
    int         total = 0;
    int         bad   = 0;
    int         req_n = 0;
    int         req_n_d = 0;
    exp_t       e_cur;
    logic [7:0] act;
    logic [1:0] tab [4];
    int         pos0 = 0;

    always @(posedge Clk6) req_n_d <= req_n;

    always @(negedge Clk6) begin
        for (int k = 0; k < req_n_d; k++) begin
            total++;
            if (sbq.size() == 0) begin
                bad++;
                $display("FAIL scoreboard_underflow: actual=empty required=entry");
            end else begin
                e_cur = sbq.pop_front();
                case (e_cur.kind)
                    0:       act = {1'b0, rd_s};
                    1:       act = {6'b0, flags_s};
                    2:       act = {1'b0, rd_w};
                    default: act = {6'b0, flags_w};
                endcase
                if (act !== e_cur.exp) begin
                    bad++;
                    $display("FAIL %s (kind %0d): actual=%h required=%h", e_cur.name, e_cur.kind, act, e_cur.exp);
                end
            end
        end
    end

    task automatic push_exp(input int kind, input logic [7:0] val, input string nm);
        exp_t e;
        e.kind = kind;
        e.exp  = val;
        e.name = nm;
        sbq.push_back(e);
    endtask

    task automatic issue(input int n);
        req_n = n;
        @(negedge Clk6);
        req_n = 0;
    endtask

    task automatic rd(input logic [2:0] s, input logic [6:0] es, input logic [6:0] ew, input string nm);
        Sel = s;
        push_exp(0, {1'b0, es}, nm);
        push_exp(2, {1'b0, ew}, nm);
        issue(2);
    endtask

    task automatic fl(input logic [1:0] ex, input string nm);
        push_exp(1, {6'b0, ex}, nm);
        push_exp(3, {6'b0, ex}, nm);
        issue(2);
    endtask

    task automatic step0(input int d, input int hold);
        pos0 = (pos0 + d + 4) % 4;
        SteerA_n[0] = tab[pos0][1];
        SteerB_n[0] = tab[pos0][0];
        repeat (hold) @(negedge Clk6);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [6:0] ex;
        // Active-low {A_n,B_n} in clockwise order.
        tab[0] = 2'b11; tab[1] = 2'b10; tab[2] = 2'b00; tab[3] = 2'b01;
        Reset = 1'b1; SteerA_n = '1; SteerB_n = '1; Clr = '0; Sel = '0;
        repeat (4) @(negedge Clk6);
        Reset = 1'b0;
        repeat (20) @(negedge Clk6);
        rd(3'd0, 7'h00, 7'h00, "reset_ch0");
        rd(3'd1, 7'h00, 7'h00, "reset_ch1");
        rd(3'd5, 7'h00, 7'h00, "reset_sel5");
        fl(2'b00, "reset_flags");

        // First edge samples pins at P1, count lands at P7.
        step0(1, 0);
        repeat (5) @(negedge Clk6);
        fl(2'b00, "latency_edge6");
        fl(2'b01, "latency_edge7");
        repeat (4) @(negedge Clk6);
        step0(1, 10);
        step0(1, 10);
        step0(1, 10);
        rd(3'd0, 7'h64, 7'h64, "cw4_ch0");
        fl(2'b01, "cw4_flags");

        for (int p = 0; p < 2; p++) begin
            SteerA_n[1] = 1'b0;
            repeat (2) @(negedge Clk6);
            SteerA_n[1] = 1'b1;
            repeat (6) @(negedge Clk6);
        end
        SteerA_n[1] = 1'b0; SteerB_n[1] = 1'b0;
        repeat (10) @(negedge Clk6);
        rd(3'd1, 7'h10, 7'h10, "glitch_illegal_ch1");
        rd(3'd0, 7'h64, 7'h64, "ch0_untouched");
        fl(2'b01, "glitch_flags");
        SteerA_n[1] = 1'b1; SteerB_n[1] = 1'b1;
        repeat (10) @(negedge Clk6);
        rd(3'd1, 7'h10, 7'h10, "ch1_restore");

        Clr = 2'b01;
        @(negedge Clk6);
        Clr = '0;
        repeat (2) @(negedge Clk6);
        rd(3'd0, 7'h00, 7'h00, "clr_idle_ch0");
        fl(2'b00, "clr_idle_flags");

        for (int n = 0; n < 10; n++) step0(-1, 10);
        rd(3'd0, 7'h48, 7'h46, "ccw10_ch0");
        fl(2'b01, "ccw10_flags");

        // Clr high exactly at the edge that would apply this step.
        step0(1, 0);
        repeat (6) @(negedge Clk6);
        Clr = 2'b01;
        @(negedge Clk6);
        Clr = '0;
        repeat (5) @(negedge Clk6);
        rd(3'd0, 7'h00, 7'h00, "clr_beats_event");
        fl(2'b00, "clr_beats_flags");
        step0(1, 10);
        rd(3'd0, 7'h61, 7'h61, "step_after_clr");

        for (int s = 0; s < 8; s++) begin
            ex = (s == 0) ? 7'h61 : (s == 1) ? 7'h10 : 7'h00;
            rd(3'(s), ex, ex, $sformatf("sel_sweep_%0d", s));
        end

        Reset = 1'b1;
        rd(3'd0, 7'h00, 7'h00, "reset_mid_rd");
        fl(2'b00, "reset_mid_flags");
        Reset = 1'b0;
        repeat (20) @(negedge Clk6);
        rd(3'd0, 7'h00, 7'h00, "post_reset_ch0");
        rd(3'd1, 7'h00, 7'h00, "post_reset_ch1");

        repeat (3) @(negedge Clk6);
        total++;
        if (sbq.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: actual=%0d required=0", sbq.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
